tlb_assoc: RTL and testbench
============================

Name:
tlb_assoc

Overview:
- Parametrised, fully associative TLB. Successor to the fixed 64-entry combinational CAM.
- Adds stored valid bits, a registered lookup response, a fill port with duplicate detection and round-robin replacement, single-VPN invalidate, and a sequential flush engine.
- Sits between the address-generation stage and the page-table walker. The walker drives fills; the OS/CSR path drives invalidate and flush.

Parameters:
VPN_W, 34, virtual page number width
PFN_W, 26, physical frame number width
ENTRIES, 64, number of entries, power of two, >= 2
IDX_W, $clog2(ENTRIES), entry index width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
lookup_valid  in  1  lookup request this cycle
lookup_vpn  in  VPN_W  VPN to translate
resp_valid  out  1  response valid, one cycle after request
resp_hit  out  1  translation found
resp_pfn  out  PFN_W  translated PFN; 0 on miss
resp_idx  out  IDX_W  matching entry index; 0 on miss
fill_valid  in  1  write request from walker
fill_vpn  in  VPN_W  VPN to install
fill_pfn  in  PFN_W  PFN to install
fill_ready  out  1  fill accepted when fill_valid && fill_ready
inv_valid  in  1  invalidate entry matching inv_vpn
inv_vpn  in  VPN_W  VPN to invalidate
flush_req  in  1  start full flush (pulse)
busy  out  1  flush in progress

Behaviour:
- Reset (async): all valid bits 0, resp_valid/resp_hit/resp_pfn/resp_idx 0, fill_ready 0, busy 0, victim pointer 0, FSM IDLE. VPN/PFN arrays need no reset.
- Match: entry i matches when valid[i] && vpn[i]==key across the full VPN_W. On multiple matches the lowest index wins.
- Lookup: latency 1. The response registers capture the match result of cycle N, with array contents as they stood at the start of cycle N. Writes in cycle N are not visible until N+1. resp_valid = registered lookup_valid.
- FSM IDLE:
  - fill_ready=1.
  - flush_req -> FLUSH, flush counter=0, busy=1 next cycle.
  - Else inv_valid clears valid on every matching entry in one cycle.
  - Else an accepted fill writes vpn/pfn and sets valid.
- Fill target selection, in order: (1) existing matching entry, which is overwritten so no duplicates arise; (2) lowest-index invalid entry; (3) the entry at the victim pointer, after which the pointer increments modulo ENTRIES.
- The victim pointer advances only on case (3).
- Priority within one cycle: flush_req > inv_valid > fill. A fill that loses to inv_valid is not accepted: fill_ready is 0 in that cycle.
- Same-cycle inv_vpn == fill_vpn: the invalidate wins and the fill retries next cycle.
- FSM FLUSH:
  - Clears valid[cnt] each cycle, cnt+1.
  - After cnt==ENTRIES-1 is cleared -> IDLE. busy deasserts that same edge, so busy is high for exactly ENTRIES cycles.
  - fill_ready=0; inv_valid and flush_req are ignored.
  - Lookups still respond, and resp_hit is forced 0 throughout FLUSH.
  - The victim pointer resets to 0 on flush completion.
- Reset mid-flush: immediate async clear to reset state; the flush is not resumed.
- Widths: counter and victim pointer are IDX_W bits and wrap naturally.

Optional Feature:
- Macro: TLB_STATS_EN.
- When defined, adds outputs hit_cnt (32) and miss_cnt (32), which count resp_valid cycles with resp_hit=1 and resp_hit=0 respectively. Counters saturate at 32'hFFFFFFFF, reset to 0 on rst, and are not cleared by flush.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Fill vpn=34'h0_0000_1234, pfn=26'h00ABC; next cycle lookup same vpn -> one cycle later resp_valid=1, resp_hit=1, resp_pfn=26'h00ABC, resp_idx=0.
- Fill the same vpn again with pfn=26'h00DEF -> still entry 0, pfn updated; entry 1 remains invalid (lookup of any other VPN misses).
- Fill ENTRIES distinct VPNs, then one more -> it lands in entry 0, victim pointer=1; lookup of the first VPN now misses.
- inv_valid and fill_valid in the same cycle with equal VPN -> fill_ready=0 that cycle; lookup next cycle misses.
- flush_req pulse with a full TLB -> busy=1 for exactly ENTRIES cycles, fill_ready=0, lookup mid-flush gives resp_hit=0; afterwards all lookups miss and the next fill goes to entry 0.
- Assert rst during cycle 10 of a flush -> busy=0 and resp_* = 0 immediately; after release, lookups miss and fill_ready=1.

Source files
------------

// File: rtl/tlb_assoc.sv
// Fully associative TLB with registered lookup, de-duplicating round-robin fill,
// single-VPN invalidate and a sequential flush engine. Define TLB_STATS_EN for hit/miss counters.
module tlb_assoc #(
    parameter int unsigned VPN_W   = 34,
    parameter int unsigned PFN_W   = 26,
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lookup_valid,
    input  logic [VPN_W-1:0] lookup_vpn,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic [PFN_W-1:0] resp_pfn,
    output logic [IDX_W-1:0] resp_idx,
    input  logic             fill_valid,
    input  logic [VPN_W-1:0] fill_vpn,
    input  logic [PFN_W-1:0] fill_pfn,
    output logic             fill_ready,
    input  logic             inv_valid,
    input  logic [VPN_W-1:0] inv_vpn,
    input  logic             flush_req,
    output logic             busy
`ifdef TLB_STATS_EN
    ,
    output logic [31:0]      hit_cnt,
    output logic [31:0]      miss_cnt
`endif
);

    typedef enum logic [0:0] {StIdle, StFlush} state_e;

    state_e             state_q, state_d;
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [VPN_W-1:0]   vpn_q [ENTRIES];
    logic [PFN_W-1:0]   pfn_q [ENTRIES];
    logic [IDX_W-1:0]   cnt_q, cnt_d, victim_q, victim_d;
    logic               resp_valid_q, resp_valid_d, resp_hit_q, resp_hit_d;
    logic [PFN_W-1:0]   resp_pfn_q, resp_pfn_d;
    logic [IDX_W-1:0]   resp_idx_q, resp_idx_d;

    logic               lk_hit, fm_hit, free_found, fill_we;
    logic [IDX_W-1:0]   lk_idx, fm_idx, free_idx, fill_idx;
    logic [ENTRIES-1:0] inv_mask;

    // Descending scans so the lowest matching index is the one that sticks.
    always_comb begin
        lk_hit     = 1'b0;
        lk_idx     = '0;
        fm_hit     = 1'b0;
        fm_idx     = '0;
        free_found = 1'b0;
        free_idx   = '0;
        inv_mask   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && vpn_q[i] == lookup_vpn) begin
                lk_hit = 1'b1;
                lk_idx = IDX_W'(i);
            end
            if (valid_q[i] && vpn_q[i] == fill_vpn) begin
                fm_hit = 1'b1;
                fm_idx = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            inv_mask[i] = valid_q[i] && vpn_q[i] == inv_vpn;
        end
    end

    assign fill_idx   = fm_hit ? fm_idx : (free_found ? free_idx : victim_q);
    assign fill_ready = !rst && state_q == StIdle && !flush_req && !inv_valid;

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        victim_d = victim_q;
        fill_we  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (flush_req) begin
                    state_d = StFlush;
                    cnt_d   = '0;
                end else if (inv_valid) begin
                    valid_d = valid_q & ~inv_mask;
                end else if (fill_valid) begin
                    fill_we           = 1'b1;
                    valid_d[fill_idx] = 1'b1;
                    if (!fm_hit && !free_found) begin
                        victim_d = victim_q + 1'b1;
                    end
                end
            end
            StFlush: begin
                valid_d[cnt_q] = 1'b0;
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(ENTRIES - 1)) begin
                    state_d  = StIdle;
                    victim_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Response sees array contents from the start of the cycle; hits are masked during flush.
    always_comb begin
        resp_valid_d = lookup_valid;
        resp_hit_d   = lk_hit && state_q == StIdle;
        resp_pfn_d   = resp_hit_d ? pfn_q[lk_idx] : '0;
        resp_idx_d   = resp_hit_d ? lk_idx : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            valid_q      <= '0;
            cnt_q        <= '0;
            victim_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_pfn_q   <= '0;
            resp_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            cnt_q        <= cnt_d;
            victim_q     <= victim_d;
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            resp_pfn_q   <= resp_pfn_d;
            resp_idx_q   <= resp_idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            vpn_q[fill_idx] <= fill_vpn;
            pfn_q[fill_idx] <= fill_pfn;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_hit   = resp_hit_q;
    assign resp_pfn   = resp_pfn_q;
    assign resp_idx   = resp_idx_q;
    assign busy       = state_q == StFlush;

`ifdef TLB_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (resp_valid_q && resp_hit_q && hit_cnt_q != 32'hFFFF_FFFF) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if (resp_valid_q && !resp_hit_q && miss_cnt_q != 32'hFFFF_FFFF) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_tlb_assoc.sv
// Scoreboard bench for tlb_assoc: lookups push expected responses, a negedge monitor checks them.
module tb_tlb_assoc;
    localparam int VPN_W   = 34;
    localparam int PFN_W   = 26;
    localparam int ENTRIES = 64;
    localparam int IDX_W   = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             lookup_valid = 1'b0;
    logic [VPN_W-1:0] lookup_vpn = '0;
    logic             resp_valid, resp_hit, fill_ready, busy;
    logic [PFN_W-1:0] resp_pfn;
    logic [IDX_W-1:0] resp_idx;
    logic             fill_valid = 1'b0;
    logic [VPN_W-1:0] fill_vpn = '0;
    logic [PFN_W-1:0] fill_pfn = '0;
    logic             inv_valid = 1'b0;
    logic [VPN_W-1:0] inv_vpn = '0;
    logic             flush_req = 1'b0;

    typedef struct {
        logic             hit;
        logic [PFN_W-1:0] pfn;
        logic [IDX_W-1:0] idx;
        string            name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   nb;

    tlb_assoc #(.VPN_W(VPN_W), .PFN_W(PFN_W), .ENTRIES(ENTRIES)) dut (
        .clk(clk), .rst(rst),
        .lookup_valid(lookup_valid), .lookup_vpn(lookup_vpn),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_pfn(resp_pfn), .resp_idx(resp_idx),
        .fill_valid(fill_valid), .fill_vpn(fill_vpn), .fill_pfn(fill_pfn), .fill_ready(fill_ready),
        .inv_valid(inv_valid), .inv_vpn(inv_vpn),
        .flush_req(flush_req), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp_valid", 64'(resp_valid), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_hit"}, 64'(resp_hit), 64'(e.hit));
                check({e.name, "_pfn"}, 64'(resp_pfn), 64'(e.pfn));
                check({e.name, "_idx"}, 64'(resp_idx), 64'(e.idx));
            end
        end
    end

    task automatic do_fill(input logic [VPN_W-1:0] vpn, input logic [PFN_W-1:0] pfn);
        fill_valid = 1'b1;
        fill_vpn   = vpn;
        fill_pfn   = pfn;
        #1;
        check("fill_ready_idle", 64'(fill_ready), 64'd1);
        @(posedge clk); #1;
        fill_valid = 1'b0;
    endtask

    task automatic do_lookup(input logic [VPN_W-1:0] vpn, input logic hit,
                             input logic [PFN_W-1:0] pfn, input logic [IDX_W-1:0] idx,
                             input string name);
        exp_t e;
        e.hit = hit; e.pfn = pfn; e.idx = idx; e.name = name;
        exp_q.push_back(e);
        lookup_valid = 1'b1;
        lookup_vpn   = vpn;
        @(posedge clk); #1;
        lookup_valid = 1'b0;
    endtask

    initial begin
        #2;
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_hit", 64'(resp_hit), 64'd0);
        check("rst_resp_pfn", 64'(resp_pfn), 64'd0);
        check("rst_resp_idx", 64'(resp_idx), 64'd0);
        check("rst_fill_ready", 64'(fill_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        do_fill(34'h0_0000_1234, 26'h00ABC);
        do_lookup(34'h0_0000_1234, 1'b1, 26'h00ABC, 6'd0, "first_fill");
        do_fill(34'h0_0000_1234, 26'h00DEF);
        do_lookup(34'h0_0000_1234, 1'b1, 26'h00DEF, 6'd0, "dup_fill");
        do_lookup(34'h0_0000_5555, 1'b0, '0, '0, "other_miss");
        do_fill(34'h0_0000_2000, 26'h00001);
        do_lookup(34'h0_0000_2000, 1'b1, 26'h00001, 6'd1, "second_entry");

        // Fill the rest, then overflow twice to walk the victim pointer.
        for (int i = 2; i < ENTRIES; i++) do_fill(34'h1_0000 + 34'(i), 26'h100 + 26'(i));
        do_lookup(34'h1_0005, 1'b1, 26'h105, 6'd5, "full_entry5");
        do_fill(34'h3_0000_0000, 26'h777);
        do_lookup(34'h0_0000_1234, 1'b0, '0, '0, "evicted0");
        do_lookup(34'h3_0000_0000, 1'b1, 26'h777, 6'd0, "victim0");
        do_fill(34'h3_0000_0001, 26'h778);
        do_lookup(34'h0_0000_2000, 1'b0, '0, '0, "evicted1");
        do_lookup(34'h3_0000_0001, 1'b1, 26'h778, 6'd1, "victim1");

        // Invalidate and fill of the same VPN in one cycle: invalidate wins.
        inv_valid = 1'b1; inv_vpn = 34'h1_0005;
        fill_valid = 1'b1; fill_vpn = 34'h1_0005; fill_pfn = 26'h999;
        #1;
        check("inv_fill_ready", 64'(fill_ready), 64'd0);
        @(posedge clk); #1;
        inv_valid = 1'b0; fill_valid = 1'b0;
        do_lookup(34'h1_0005, 1'b0, '0, '0, "after_inv");
        do_fill(34'h1_0005, 26'h999);
        do_lookup(34'h1_0005, 1'b1, 26'h999, 6'd5, "refill_hole");

        // Full flush.
        flush_req = 1'b1;
        #1;
        check("flush_req_fill_ready", 64'(fill_ready), 64'd0);
        @(posedge clk); #1;
        flush_req = 1'b0;
        nb = 0;
        while (busy && nb < 200) begin
            nb++;
            if (nb == 2) check("flush_fill_ready", 64'(fill_ready), 64'd0);
            if (nb == 3) begin
                exp_t e;
                e.hit = 1'b0; e.pfn = '0; e.idx = '0; e.name = "mid_flush";
                exp_q.push_back(e);
                lookup_valid = 1'b1;
                lookup_vpn   = 34'h1_0010;
            end else begin
                lookup_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        lookup_valid = 1'b0;
        check("flush_busy_cycles", 64'(nb), 64'(ENTRIES));
        do_lookup(34'h1_0010, 1'b0, '0, '0, "post_flush_a");
        do_lookup(34'h3_0000_0000, 1'b0, '0, '0, "post_flush_b");
        do_fill(34'h0_0000_4444, 26'h44);
        do_lookup(34'h0_0000_4444, 1'b1, 26'h44, 6'd0, "post_flush_fill");

        // Reset in the middle of a flush.
        for (int i = 1; i < 20; i++) do_fill(34'h5000 + 34'(i), 26'(i));
        do_lookup(34'h5000 + 34'd15, 1'b1, 26'd15, 6'd15, "pre_rst_fill");
        flush_req = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0;
        nb = 0;
        while (busy && nb < 200) begin
            nb++;
            if (nb == 10) break;
            lookup_valid = (nb == 9);
            lookup_vpn   = 34'h5000;
            @(posedge clk); #1;
        end
        lookup_valid = 1'b0;
        check("pre_rst_busy", 64'(busy), 64'd1);
        check("pre_rst_resp_valid", 64'(resp_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("midflush_rst_busy", 64'(busy), 64'd0);
        check("midflush_rst_resp_valid", 64'(resp_valid), 64'd0);
        check("midflush_rst_resp_hit", 64'(resp_hit), 64'd0);
        check("midflush_rst_resp_pfn", 64'(resp_pfn), 64'd0);
        check("midflush_rst_resp_idx", 64'(resp_idx), 64'd0);
        check("midflush_rst_fill_ready", 64'(fill_ready), 64'd0);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_fill_ready", 64'(fill_ready), 64'd1);
        check("post_rst_busy", 64'(busy), 64'd0);
        do_lookup(34'h5000 + 34'd15, 1'b0, '0, '0, "post_rst_miss_a");
        do_lookup(34'h0_0000_4444, 1'b0, '0, '0, "post_rst_miss_b");
        do_fill(34'h6000, 26'h66);
        do_lookup(34'h6000, 1'b1, 26'h66, 6'd0, "post_rst_fill");

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
